// File: rtl/kl10_ad_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : kl10_ad_pipe
//  Description : Two-stage pipelined 36-bit adder/logic unit built from
//                4-bit groups. Stage 1 registers the operands and the group
//                generate/propagate terms. Stage 2 resolves carries with
//                two-level lookahead (groups -> super-groups of four) and
//                registers the result and flags. Both sides use valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module kl10_ad_pipe #(
    parameter  int WIDTH = 36,
    localparam int NGRP  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [NGRP-1:0]  grp_g_n,
    output logic [NGRP-1:0]  grp_p_n
);

    // Number of lookahead super-groups (four groups each, last may be short)
    localparam int NSG = (NGRP + 3) / 4;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_ADC   = 3'd2;
    localparam logic [2:0] OP_SBC   = 3'd3;
    localparam logic [2:0] OP_PASSA = 3'd4;
    localparam logic [2:0] OP_PASSB = 3'd5;
    localparam logic [2:0] OP_AND   = 3'd6;
    localparam logic [2:0] OP_OR    = 3'd7;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_free;
    logic w_s1_adv;
    logic w_accept;

    // Stage-1 registers
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_bx;
    logic             r_s1_c0;
    logic [NGRP-1:0]  r_s1_grp_g;
    logic [NGRP-1:0]  r_s1_grp_p;

    assign w_s2_free = !out_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage-1 front end: effective B and carry-in
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;
    logic [NGRP-1:0]  w_grp_g;
    logic [NGRP-1:0]  w_grp_p;

    // Subtracts invert B; carry-in is forced for ADD/SUB, taken from cin for ADC/SBC
    always_comb begin
        w_bx = b;
        w_c0 = 1'b0;
        case (op)
            OP_SUB: begin
                w_bx = ~b;
                w_c0 = 1'b1;
            end
            OP_ADC: w_c0 = cin;
            OP_SBC: begin
                w_bx = ~b;
                w_c0 = cin;
            end
            default: begin
                w_bx = b;
                w_c0 = 1'b0;
            end
        endcase
    end

    // Per-group generate/propagate, one 4-bit slice per group
    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            logic [3:0] w_g;
            logic [3:0] w_p;
            assign w_g = a[4*gi +: 4] & w_bx[4*gi +: 4];
            assign w_p = a[4*gi +: 4] | w_bx[4*gi +: 4];
            assign w_grp_g[gi] = w_g[3]
                               | (w_p[3] & w_g[2])
                               | (w_p[3] & w_p[2] & w_g[1])
                               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
            assign w_grp_p[gi] = &w_p;
        end
    endgenerate

    // Stage 1 captures a beat on accept and empties when it moves downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 3'd0;
            r_s1_a     <= '0;
            r_s1_bx    <= '0;
            r_s1_c0    <= 1'b0;
            r_s1_grp_g <= '0;
            r_s1_grp_p <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= op;
            r_s1_a     <= a;
            r_s1_bx    <= w_bx;
            r_s1_c0    <= w_c0;
            r_s1_grp_g <= w_grp_g;
            r_s1_grp_p <= w_grp_p;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage-2 carry resolution and result formation
    // ------------------------------------------------------------------
    logic [NSG-1:0]   w_sg_g;
    logic [NSG-1:0]   w_sg_p;
    logic [NSG-1:0]   w_sc;
    logic [NGRP-1:0]  w_gc;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_bg;
    logic [WIDTH-1:0] w_bp;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout_arith;
    logic             w_run;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;

    // Two-level lookahead: super-group G/P, carries into each super-group,
    // carries into each group, then carries into each bit
    always_comb begin
        w_sg_g       = '0;
        w_sg_p       = '1;
        w_sc         = '0;
        w_gc         = '0;
        w_c          = '0;
        w_run        = 1'b0;
        w_cout_arith = 1'b0;
        w_bg         = r_s1_a & r_s1_bx;
        w_bp         = r_s1_a | r_s1_bx;

        for (int j = 0; j < NGRP; j++) begin
            w_sg_g[j/4] = r_s1_grp_g[j] | (r_s1_grp_p[j] & w_sg_g[j/4]);
            w_sg_p[j/4] = r_s1_grp_p[j] & w_sg_p[j/4];
        end

        w_run = r_s1_c0;
        for (int k = 0; k < NSG; k++) begin
            w_sc[k] = w_run;
            w_run   = w_sg_g[k] | (w_sg_p[k] & w_run);
        end
        w_cout_arith = w_run;

        w_run = 1'b0;
        for (int j = 0; j < NGRP; j++) begin
            if (j % 4 == 0) begin
                w_run = w_sc[j/4];
            end
            w_gc[j] = w_run;
            w_run   = r_s1_grp_g[j] | (r_s1_grp_p[j] & w_run);
        end

        w_run = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % 4 == 0) begin
                w_run = w_gc[i/4];
            end
            w_c[i] = w_run;
            w_run  = w_bg[i] | (w_bp[i] & w_run);
        end

        w_sum = r_s1_a ^ r_s1_bx ^ w_c;
    end

    // Operation select; logic ops never report carry or overflow
    always_comb begin
        w_res  = w_sum;
        w_cout = w_cout_arith;
        w_ovf  = w_cout_arith ^ w_c[WIDTH-1];
        case (r_s1_op)
            OP_PASSA: w_res = r_s1_a;
            OP_PASSB: w_res = r_s1_bx;
            OP_AND:   w_res = r_s1_a & r_s1_bx;
            OP_OR:    w_res = r_s1_a | r_s1_bx;
            default:  w_res = w_sum;
        endcase
        if (r_s1_op[2]) begin
            w_cout = 1'b0;
            w_ovf  = 1'b0;
        end
    end

    // Stage 2 loads when stage 1 advances; holds while downstream stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            grp_g_n   <= '1;
            grp_p_n   <= '1;
        end else if (w_s1_adv) begin
            out_valid <= 1'b1;
            result    <= w_res;
            cout      <= w_cout;
            ovf       <= w_ovf;
            grp_g_n   <= ~r_s1_grp_g;
            grp_p_n   <= ~r_s1_grp_p;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kl10_ad_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kl10_ad_pipe
//  Description : Directed self-checking bench for kl10_ad_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kl10_ad_pipe;

    localparam int WIDTH = 36;
    localparam int NGRP  = WIDTH / 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic [NGRP-1:0]  grp_g_n;
    logic [NGRP-1:0]  grp_p_n;

    int checks = 0;
    int errors = 0;

    kl10_ad_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .grp_g_n   (grp_g_n),
        .grp_p_n   (grp_p_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge and stop at the negedge where it is valid
    task automatic run_one(input logic [2:0] t_op, input logic [WIDTH-1:0] t_a,
                           input logic [WIDTH-1:0] t_b, input logic t_cin);
        op       = t_op;
        a        = t_a;
        b        = t_b;
        cin      = t_cin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("latency_not_yet", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("latency_valid", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {28'd0, result}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_grp_g_n", {55'd0, grp_g_n}, 64'h1FF);
        check("rst_grp_p_n", {55'd0, grp_p_n}, 64'h1FF);
        reset = 1'b0;
        @(negedge clk);

        // ADD into the sign bit: overflow without carry
        run_one(3'd0, 36'o377777777777, 36'd1, 1'b0);
        check("add_ovf_result", {28'd0, result}, {28'd0, 36'o400000000000});
        check("add_ovf_cout", {63'd0, cout}, 64'd0);
        check("add_ovf_ovf", {63'd0, ovf}, 64'd1);

        // ADD wrap: OR-form propagate is set in every group, group 0 generates
        run_one(3'd0, 36'o777777777777, 36'd1, 1'b0);
        check("add_wrap_result", {28'd0, result}, 64'd0);
        check("add_wrap_cout", {63'd0, cout}, 64'd1);
        check("add_wrap_ovf", {63'd0, ovf}, 64'd0);
        check("add_wrap_grp_p_n", {55'd0, grp_p_n}, 64'h000);
        check("add_wrap_grp_g_n", {55'd0, grp_g_n}, 64'h1FE);

        // SUB with borrow and without
        run_one(3'd1, 36'd5, 36'd7, 1'b0);
        check("sub_borrow_result", {28'd0, result}, {28'd0, 36'o777777777776});
        check("sub_borrow_cout", {63'd0, cout}, 64'd0);
        check("sub_borrow_ovf", {63'd0, ovf}, 64'd0);
        run_one(3'd1, 36'd7, 36'd5, 1'b0);
        check("sub_pos_result", {28'd0, result}, 64'd2);
        check("sub_pos_cout", {63'd0, cout}, 64'd1);
        check("sub_pos_ovf", {63'd0, ovf}, 64'd0);

        // Carry-in ops
        run_one(3'd2, 36'o17, 36'd0, 1'b1);
        check("adc_result", {28'd0, result}, 64'o20);
        check("adc_cout", {63'd0, cout}, 64'd0);
        run_one(3'd3, 36'd3, 36'd3, 1'b0);
        check("sbc_result", {28'd0, result}, {28'd0, 36'o777777777777});
        check("sbc_cout", {63'd0, cout}, 64'd0);
        check("sbc_ovf", {63'd0, ovf}, 64'd0);

        // Logic ops: no carry/overflow even when an add would carry
        run_one(3'd4, 36'o777777777777, 36'd1, 1'b0);
        check("passa_result", {28'd0, result}, {28'd0, 36'o777777777777});
        check("passa_cout", {63'd0, cout}, 64'd0);
        check("passa_ovf", {63'd0, ovf}, 64'd0);
        check("passa_grp_g_n", {55'd0, grp_g_n}, 64'h1FE);
        run_one(3'd5, 36'o123456701234, 36'o765432107654, 1'b1);
        check("passb_result", {28'd0, result}, {28'd0, 36'o765432107654});
        run_one(3'd7, 36'o707070707070, 36'o770077007700, 1'b0);
        check("or_result", {28'd0, result}, {28'd0, 36'o777077707770});
        check("or_cout", {63'd0, cout}, 64'd0);

        // Backpressure: four ADDs, downstream stalls for three cycles
        op = 3'd0; cin = 1'b0;
        a = 36'd1; b = 36'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 36'd2; b = 36'd2;
        @(negedge clk);
        out_ready = 1'b0;
        a = 36'd3; b = 36'd3;
        #1;
        check("bp_first_valid", {63'd0, out_valid}, 64'd1);
        check("bp_first_result", {28'd0, result}, 64'd2);
        check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_result", {28'd0, result}, 64'd2);
        check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        check("bp_release_result", {28'd0, result}, 64'd2);
        @(negedge clk);
        a = 36'd4; b = 36'd4;
        check("bp_second_result", {28'd0, result}, 64'd4);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_third_result", {28'd0, result}, 64'd6);
        @(negedge clk);
        check("bp_fourth_result", {28'd0, result}, 64'd8);
        check("bp_fourth_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // Reset with two beats in flight
        op = 3'd0; a = 36'd10; b = 36'd20; in_valid = 1'b1;
        @(negedge clk);
        a = 36'd1; b = 36'd2;
        @(negedge clk);
        check("mid_first_result", {28'd0, result}, 64'd30);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_result", {28'd0, result}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_after_1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("mid_after_2", {63'd0, out_valid}, 64'd0);
        run_one(3'd6, 36'o707070707070, 36'o770077007700, 1'b0);
        check("and_result", {28'd0, result}, {28'd0, 36'o700070007000});
        check("and_cout", {63'd0, cout}, 64'd0);
        check("and_ovf", {63'd0, ovf}, 64'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
